// File: rtl/quad_steer_decoder.sv
// quad_steer_decoder: quadrature A/B steering decoder.
// Sync, glitch filter, x4 step decode, wrapping position, saturating delta.
module quad_steer_decoder #(
  parameter int FILT_CYCLES = 16,
  parameter int POS_WIDTH   = 8,
  parameter int DELTA_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          Reset_I,
  input  logic                          steerA,
  input  logic                          steerB,
  input  logic                          invert,
  output logic                          step_cw,
  output logic                          step_ccw,
  output logic [POS_WIDTH-1:0]          position,
  input  logic                          delta_rd,
  output logic signed [DELTA_WIDTH-1:0] delta_q,
  output logic                          err,
  input  logic                          err_clr
);

  localparam logic [7:0] FILT_LAST = 8'(FILT_CYCLES - 1);
  localparam logic [8:0] INIT_LAST = 9'(FILT_CYCLES + 1);
  localparam logic signed [DELTA_WIDTH-1:0] ACC_MAX =
    {1'b0, {(DELTA_WIDTH-1){1'b1}}};
  localparam logic signed [DELTA_WIDTH-1:0] ACC_MIN =
    {1'b1, {(DELTA_WIDTH-1){1'b0}}};
  localparam logic signed [DELTA_WIDTH-1:0] ACC_ONE =
    DELTA_WIDTH'(1);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  // bit 1 is phase A, bit 0 is phase B
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic [1:0] r_filt;
  logic [1:0] r_prev;
  logic [7:0] r_cnt [2];
  logic [8:0] r_init_cnt;
  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_load;
  logic       w_track;
  logic [1:0] w_prev_idx;
  logic [1:0] w_cur_idx;
  logic [1:0] w_diff;
  logic       w_fwd;
  logic       w_rev;
  logic       w_bad;
  logic       w_cw;
  logic       w_ccw;
  logic signed [DELTA_WIDTH-1:0] r_acc;
  logic signed [DELTA_WIDTH-1:0] w_acc_nxt;

  // two-flop synchroniser for both raw phases
  always_ff @(posedge CLK or negedge Reset_I) begin
    if (!Reset_I) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= {steerA, steerB};
      r_sync <= r_meta;
    end
  end

  // per-phase stability filter; INIT end loads synced levels directly
  always_ff @(posedge CLK or negedge Reset_I) begin
    if (!Reset_I) begin
      r_filt <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else if (w_load) begin
      r_filt <= r_sync;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] != r_filt[i]) begin
          if (r_cnt[i] == FILT_LAST) begin
            r_filt[i] <= r_sync[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // FSM state register and INIT settle counter
  always_ff @(posedge CLK or negedge Reset_I) begin
    if (!Reset_I) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 9'd1;
    end
  end

  // FSM next state: leave INIT after FILT_CYCLES+2 cycles
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_INIT:  if (r_init_cnt == INIT_LAST) w_state_nxt = S_TRACK;
      S_TRACK: w_state_nxt = S_TRACK;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // FSM outputs: one load pulse at INIT end, then tracking
  always_comb begin
    w_load  = (r_state == S_INIT) && (r_init_cnt == INIT_LAST);
    w_track = (r_state == S_TRACK);
  end

  // Gray {A,B} 00,10,11,01 maps to index {B, A^B} = 0,1,2,3
  always_comb begin
    w_prev_idx = {r_prev[0], r_prev[1] ^ r_prev[0]};
    w_cur_idx  = {r_filt[0], r_filt[1] ^ r_filt[0]};
    w_diff     = w_cur_idx - w_prev_idx;
    w_fwd      = w_track && (w_diff == 2'd1);
    w_rev      = w_track && (w_diff == 2'd3);
    w_bad      = w_track && (w_diff == 2'd2);
    w_cw       = invert ? w_rev : w_fwd;
    w_ccw      = invert ? w_fwd : w_rev;
  end

  // saturating accumulator next value including this cycle's step
  always_comb begin
    w_acc_nxt = r_acc;
    unique case (1'b1)
      w_cw:    if (r_acc != ACC_MAX) w_acc_nxt = r_acc + ACC_ONE;
      w_ccw:   if (r_acc != ACC_MIN) w_acc_nxt = r_acc - ACC_ONE;
      default: w_acc_nxt = r_acc;
    endcase
  end

  // decode register: steps, position, delta capture, sticky error
  always_ff @(posedge CLK or negedge Reset_I) begin
    if (!Reset_I) begin
      r_prev   <= '0;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      position <= '0;
      r_acc    <= '0;
      delta_q  <= '0;
      err      <= 1'b0;
    end else begin
      r_prev   <= w_load ? r_sync : r_filt;
      step_cw  <= w_cw;
      step_ccw <= w_ccw;
      unique case (1'b1)
        w_cw:    position <= position + POS_WIDTH'(1);
        w_ccw:   position <= position - POS_WIDTH'(1);
        default: position <= position;
      endcase
      if (delta_rd) begin
        delta_q <= w_acc_nxt;
        r_acc   <= '0;
      end else begin
        r_acc <= w_acc_nxt;
      end
      if (w_bad)        err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule
